alu_mult_seq: RTL and testbench

Sequential shift-add multiply(-accumulate) unit, downstream of the ALU instruction decoder. When the decoder flags a multiply (`multiplication` high for MLR/MLM), the datapath presents the selected Rn/Rm operands and an optional accumulate operand here. The unit produces a double-width product over WIDTH cycles under a start/busy/done handshake. The low half returns to the ALU output mux; the high half and flags go to the status logic.

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_mult_seq.sv | 91 +++++++++
 tb/tb_alu_mult_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the multiplier state encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/alu_mult_seq.sv
// Sequential shift-add multiply-accumulate: {prod_hi, prod_lo} = op_a * op_b + acc,
// one multiplier bit per cycle, start/busy/done handshake, unsigned.
module alu_mult_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi,
    output logic             carry,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    mult_state_t      r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_count;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_count == CW'(WIDTH - 1));

    // The sum's carry bit lands in the MSB of the shifted pair, so nothing is lost.
    assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_prod = {w_sum, r_lo[WIDTH-1:1]};

    // NOTE: every register here is sequential state, so only non-blocking assignments
    // are used; a blocking write would let later statements see the new value this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_count <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            prod_lo <= '0;
            prod_hi <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_a     <= op_a;
                        r_hi    <= acc;
                        r_lo    <= op_b;
                        r_count <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_hi    <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo    <= w_prod[WIDTH-1:0];
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        prod_hi <= w_prod[2*WIDTH-1:WIDTH];
                        prod_lo <= w_prod[WIDTH-1:0];
                        carry   <= (w_prod[2*WIDTH-1:WIDTH] != '0);
                        zero    <= (w_prod == '0);
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Scoreboard bench for alu_mult_seq: directed MAC vectors with hand-computed results.
module tb_alu_mult_seq;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         carry;
        logic         zero;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] acc;
    logic         busy;
    logic         done;
    logic [W-1:0] prod_lo;
    logic [W-1:0] prod_hi;
    logic         carry;
    logic         zero;

    int   tests;
    int   fails;
    int   done_count;
    int   cycle;
    int   last_done_cycle;
    exp_t exp_q[$];

    alu_mult_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .acc     (acc),
        .busy    (busy),
        .done    (done),
        .prod_lo (prod_lo),
        .prod_hi (prod_hi),
        .carry   (carry),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse pops one expectation and compares the result.
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            done_count++;
            last_done_cycle = cycle;
            check("busy_in_done", 64'(busy), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("prod_lo", 64'(prod_lo), 64'(e.lo));
                check("prod_hi", 64'(prod_hi), 64'(e.hi));
                check("carry",   64'(carry),   64'(e.carry));
                check("zero",    64'(zero),    64'(e.zero));
            end
        end
    end

    // Pulse start, then wait for done; returns cycles waited and busy cycles seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          input exp_t e, output int lat, output int bcnt);
        exp_q.push_back(e);
        @(negedge clk);
        op_a = a; op_b = b; acc = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", 64'd1, 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) check(name, 64'd1, 64'd0);
    endtask

    initial begin
        int lat, bcnt, dc, first_cyc;
        tests = 0; fails = 0; done_count = 0; cycle = 0; last_done_cycle = 0;
        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; acc = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_prod", 64'({prod_hi, prod_lo}), 64'd0);
        check("rst_flags", 64'({carry, zero}), 64'd0);
        reset = 1'b0;

        // Plain multiply 3*5 with latency and busy-width checks.
        run_op(16'd3, 16'd5, 16'd0, '{lo: 16'h000F, hi: 16'h0000, carry: 1'b0, zero: 1'b0}, lat, bcnt);
        check("latency", 64'(lat), 64'd16);
        check("busy_cycles", 64'(bcnt), 64'd16);

        // Largest MAC: 0xFFFF*0xFFFF + 0xFFFF = 0xFFFF0000.
        run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, '{lo: 16'h0000, hi: 16'hFFFF, carry: 1'b1, zero: 1'b0}, lat, bcnt);

        // Zero result.
        run_op(16'h1234, 16'h0000, 16'h0000, '{lo: 16'h0000, hi: 16'h0000, carry: 1'b0, zero: 1'b1}, lat, bcnt);

        // Start and operand changes ignored while busy.
        dc = done_count;
        exp_q.push_back('{lo: 16'h0000, hi: 16'h0001, carry: 1'b1, zero: 1'b0});
        @(negedge clk);
        op_a = 16'h0100; op_b = 16'h0100; acc = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        op_a = 16'd7; op_b = 16'd7; acc = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("ignore_done_count", 64'(done_count - dc), 64'd1);

        // Reset mid-RUN aborts at once; outputs clear without a done pulse.
        dc = done_count;
        exp_q.push_back('{lo: 16'h0009, hi: 16'h0000, carry: 1'b0, zero: 1'b0});
        @(negedge clk);
        op_a = 16'd3; op_b = 16'd3; acc = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_prod", 64'({prod_hi, prod_lo}), 64'd0);
        check("abort_flags", 64'({carry, zero}), 64'd0);
        void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("abort_no_done", 64'(done_count - dc), 64'd0);
        run_op(16'd2, 16'd2, 16'd1, '{lo: 16'h0005, hi: 16'h0000, carry: 1'b0, zero: 1'b0}, lat, bcnt);

        // Back-to-back with start held: 6*7 then 9*9 loaded during DONE.
        exp_q.push_back('{lo: 16'h002A, hi: 16'h0000, carry: 1'b0, zero: 1'b0});
        exp_q.push_back('{lo: 16'h0051, hi: 16'h0000, carry: 1'b0, zero: 1'b0});
        @(negedge clk);
        op_a = 16'd6; op_b = 16'd7; acc = '0; start = 1'b1;
        wait_done("b2b_first_timeout");
        first_cyc = cycle;
        op_a = 16'd9; op_b = 16'd9;
        @(negedge clk);
        check("b2b_busy_after_done", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done("b2b_second_timeout");
        check("b2b_spacing", 64'(cycle - first_cyc), 64'd17);
        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
